// File: rtl/mem_wb_stage_pkg.sv
// Shared CPU constants for the memory/writeback slice.
// Widths, data memory depth and the byte width used by data_memory.
package mem_wb_stage_pkg;

  localparam int INSTRUCTION_WIDTH = 32;
  localparam int REGISTER_ADDR     = 5;
  localparam int RAM_DEPTH         = 256;
  localparam int BYTE_W            = 8;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return |lsb;
  endfunction

endpackage

// File: rtl/mem_wb_stage_data_memory.sv
// Byte-addressed big-endian data memory with word ports.
// Read is combinational; write lands on the rising edge.
module data_memory
  import mem_wb_stage_pkg::*;
#(
  parameter int instruction_width = INSTRUCTION_WIDTH,
  parameter int ram_depth         = RAM_DEPTH
) (
  input  logic                            clk,
  input  logic                            we,
  input  logic [$clog2(ram_depth)-3:0]    word_addr,
  input  logic [instruction_width-1:0]    wdata,
  output logic [instruction_width-1:0]    rdata
);

  localparam int LANES = instruction_width / BYTE_W;

  logic [BYTE_W-1:0] mem [ram_depth];

  // Lane 0 is the most significant byte at the lowest address.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        mem[{word_addr, 2'(i)}] <=
          wdata[instruction_width-1-i*BYTE_W -: BYTE_W];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < LANES; i++) begin
      rdata[instruction_width-1-i*BYTE_W -: BYTE_W] =
        mem[{word_addr, 2'(i)}];
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: data memory access, MEM/WB register, wb mux.
// Optional misaligned-access trap enabled by DMEM_MISALIGN_CHECK_EN.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int instruction_width = INSTRUCTION_WIDTH,
  parameter int register_addr     = REGISTER_ADDR,
  parameter int ram_depth         = RAM_DEPTH
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         mem_to_reg_pip2,
  input  logic                         reg_w_pip2,
  input  logic                         mem_r_pip2,
  input  logic                         mem_w_pip2,
  input  logic                         stall_ctr_pip2,
  input  logic [instruction_width-1:0] y_pip,
  input  logic [instruction_width-1:0] rb_data_pip2,
  input  logic [register_addr-1:0]     wb_addr_pip,
  output logic                         reg_w_pip3,
  output logic                         mem_to_reg_pip3,
  output logic [instruction_width-1:0] rd_data_pip,
  output logic [instruction_width-1:0] y_pip2,
  output logic [register_addr-1:0]     wb_addr_pip2,
  output logic [instruction_width-1:0] wb_data,
  output logic                         misalign_err
);

  localparam int AW = $clog2(ram_depth);

  logic                         misalign;
  logic                         store_en;
  logic [instruction_width-1:0] mem_rdata;
  logic                         unused_addr_bits;

  // High address bits wrap away; low bits only matter to the trap.
  assign unused_addr_bits =
    ^{y_pip[instruction_width-1:AW], y_pip[1:0]};

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = (mem_r_pip2 | mem_w_pip2) & ~stall_ctr_pip2 &
                    is_misaligned(y_pip[1:0]);

  always_ff @(posedge clk) begin
    if (!rstn) misalign_err <= 1'b0;
    else       misalign_err <= misalign;
  end
`else
  assign misalign     = 1'b0;
  assign misalign_err = 1'b0;
`endif

  assign store_en = rstn & mem_w_pip2 & ~stall_ctr_pip2 & ~misalign;

  data_memory #(
    .instruction_width (instruction_width),
    .ram_depth         (ram_depth)
  ) u_dmem (
    .clk       (clk),
    .we        (store_en),
    .word_addr (y_pip[AW-1:2]),
    .wdata     (rb_data_pip2),
    .rdata     (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      reg_w_pip3      <= 1'b0;
      mem_to_reg_pip3 <= 1'b0;
      rd_data_pip     <= '0;
      y_pip2          <= '0;
      wb_addr_pip2    <= '0;
    end else begin
      reg_w_pip3      <= reg_w_pip2 & ~stall_ctr_pip2 & ~misalign;
      mem_to_reg_pip3 <= mem_to_reg_pip2;
      y_pip2          <= y_pip;
      wb_addr_pip2    <= wb_addr_pip;
      if (mem_r_pip2) rd_data_pip <= mem_rdata;
    end
  end

  assign wb_data = mem_to_reg_pip3 ? rd_data_pip : y_pip2;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed vectors, queued expectations.
// Honours DMEM_MISALIGN_CHECK_EN when choosing misaligned-store results.
module tb_mem_wb_stage;

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  typedef struct {
    logic        rw;
    logic        m2r;
    logic [31:0] rd;
    logic [31:0] y;
    logic [4:0]  wa;
    logic [31:0] wb;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_to_reg_pip2, reg_w_pip2, mem_r_pip2;
  logic        mem_w_pip2, stall_ctr_pip2;
  logic [31:0] y_pip, rb_data_pip2;
  logic [4:0]  wb_addr_pip;
  logic        reg_w_pip3, mem_to_reg_pip3, misalign_err;
  logic [31:0] rd_data_pip, y_pip2, wb_data;
  logic [4:0]  wb_addr_pip2;

  int   applied = 0;
  int   miscompares = 0;
  exp_t q[$];

  mem_wb_stage dut (
    .clk             (clk),
    .rstn            (rstn),
    .mem_to_reg_pip2 (mem_to_reg_pip2),
    .reg_w_pip2      (reg_w_pip2),
    .mem_r_pip2      (mem_r_pip2),
    .mem_w_pip2      (mem_w_pip2),
    .stall_ctr_pip2  (stall_ctr_pip2),
    .y_pip           (y_pip),
    .rb_data_pip2    (rb_data_pip2),
    .wb_addr_pip     (wb_addr_pip),
    .reg_w_pip3      (reg_w_pip3),
    .mem_to_reg_pip3 (mem_to_reg_pip3),
    .rd_data_pip     (rd_data_pip),
    .y_pip2          (y_pip2),
    .wb_addr_pip2    (wb_addr_pip2),
    .wb_data         (wb_data),
    .misalign_err    (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic rw, input logic m2r,
                              input logic [31:0] rd, input logic [31:0] y,
                              input logic [4:0] wa, input logic [31:0] wb,
                              input logic mis);
    exp_t e;
    e.rw = rw; e.m2r = m2r; e.rd = rd; e.y = y;
    e.wa = wa; e.wb = wb; e.mis = mis;
    return e;
  endfunction

  // Inputs change on the falling edge; the DUT samples on the next rise.
  task automatic vec(input logic rst_n, input logic mr, input logic mw,
                     input logic m2r, input logic rw, input logic st,
                     input logic [31:0] y, input logic [31:0] rb,
                     input logic [4:0] wa, input exp_t e);
    @(negedge clk);
    rstn = rst_n; mem_r_pip2 = mr; mem_w_pip2 = mw;
    mem_to_reg_pip2 = m2r; reg_w_pip2 = rw; stall_ctr_pip2 = st;
    y_pip = y; rb_data_pip2 = rb; wb_addr_pip = wa;
    q.push_back(e);
  endtask

  task automatic peek(input string name, input int a,
                      input logic [7:0] exp);
    chk(name, {24'h0, dut.u_dmem.mem[a]}, {24'h0, exp});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("reg_w_pip3",      {31'h0, reg_w_pip3},      {31'h0, e.rw});
        chk("mem_to_reg_pip3", {31'h0, mem_to_reg_pip3}, {31'h0, e.m2r});
        chk("rd_data_pip",     rd_data_pip,              e.rd);
        chk("y_pip2",          y_pip2,                   e.y);
        chk("wb_addr_pip2",    {27'h0, wb_addr_pip2},    {27'h0, e.wa});
        chk("wb_data",         wb_data,                  e.wb);
        chk("misalign_err",    {31'h0, misalign_err},    {31'h0, e.mis});
      end
    end
  end

  initial begin : driver
    logic [31:0] w20;
    w20 = MIS ? 32'h01020304 : 32'h55667788;
    rstn = 1'b0; mem_r_pip2 = 0; mem_w_pip2 = 0; mem_to_reg_pip2 = 0;
    reg_w_pip2 = 0; stall_ctr_pip2 = 0; y_pip = 0; rb_data_pip2 = 0;
    wb_addr_pip = 0;

    vec(0,0,0,0,0,0, 32'h0,   32'h0, 5'd0,
        mk(0,0,32'h0,        32'h0,  5'd0, 32'h0,        0));
    vec(1,0,1,0,0,0, 32'h10,  32'hDEADBEEF, 5'd0,
        mk(0,0,32'h0,        32'h10, 5'd0, 32'h10,       0));
    vec(1,1,0,1,1,0, 32'h10,  32'h0, 5'd3,
        mk(1,1,32'hDEADBEEF, 32'h10, 5'd3, 32'hDEADBEEF, 0));
    vec(1,0,1,0,0,0, 32'h110, 32'h11223344, 5'd0,
        mk(0,0,32'hDEADBEEF, 32'h110,5'd0, 32'h110,      0));
    vec(1,1,0,1,1,0, 32'h10,  32'h0, 5'd4,
        mk(1,1,32'h11223344, 32'h10, 5'd4, 32'h11223344, 0));
    peek("peek_0x10_wrap", 16, 8'h11);
    vec(1,0,0,0,1,0, 32'h5A,  32'h0, 5'd7,
        mk(1,0,32'h11223344, 32'h5A, 5'd7, 32'h5A,       0));
    vec(1,0,1,0,0,0, 32'h20,  32'h01020304, 5'd0,
        mk(0,0,32'h11223344, 32'h20, 5'd0, 32'h20,       0));
    vec(1,0,1,0,1,1, 32'h20,  32'hCAFEF00D, 5'd9,
        mk(0,0,32'h11223344, 32'h20, 5'd9, 32'h20,       0));
    vec(1,1,0,1,1,0, 32'h20,  32'h0, 5'd2,
        mk(1,1,32'h01020304, 32'h20, 5'd2, 32'h01020304, 0));
    peek("peek_0x20_bubble", 32, 8'h01);
    peek("peek_0x23_bubble", 35, 8'h04);
    vec(1,0,1,0,0,0, 32'h30,  32'h0A0B0C0D, 5'd0,
        mk(0,0,32'h01020304, 32'h30, 5'd0, 32'h30,       0));
    vec(1,1,1,1,0,0, 32'h30,  32'h99AABBCC, 5'd0,
        mk(0,1,32'h0A0B0C0D, 32'h30, 5'd0, 32'h0A0B0C0D, 0));
    vec(1,1,0,1,1,0, 32'h30,  32'h0, 5'd6,
        mk(1,1,32'h99AABBCC, 32'h30, 5'd6, 32'h99AABBCC, 0));
    vec(1,0,1,0,1,0, 32'h22,  32'h55667788, 5'd8,
        mk(!MIS,0,32'h99AABBCC, 32'h22, 5'd8, 32'h22,    MIS));
    vec(1,1,0,1,1,0, 32'h20,  32'h0, 5'd1,
        mk(1,1,w20,          32'h20, 5'd1, w20,          0));
    peek("peek_0x22_misalign", 34, MIS ? 8'h03 : 8'h77);
    vec(1,0,0,0,1,0, 32'h77,  32'h0, 5'd5,
        mk(1,0,w20,          32'h77, 5'd5, 32'h77,       0));
    vec(0,1,1,1,1,0, 32'h10,  32'hFFFFFFFF, 5'd4,
        mk(0,0,32'h0,        32'h0,  5'd0, 32'h0,        0));
    vec(1,1,0,1,1,0, 32'h10,  32'h0, 5'd4,
        mk(1,1,32'h11223344, 32'h10, 5'd4, 32'h11223344, 0));
    peek("peek_0x10_after_reset", 16, 8'h11);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule
